// File: rtl/rcp_sysad_slave_if.sv
// SysAD pin group plus the internal request/response port of the RCP-side SysAD slave.
// The slave modport faces the design; the master modport faces the CPU and the target.
interface rcp_sysad_slave_if;
  logic [31:0] sysad_in;
  logic [4:0]  syscmd_in;
  logic        pvalid_l;
  logic [31:0] sysad_out;
  logic [4:0]  syscmd_out;
  logic        sysad_oe;
  logic        evalid_l;
  logic        eok_l;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_block;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [3:0]  req_nwords;
  logic [2:0]  wbuf_idx;
  logic [31:0] wbuf_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic        proto_err;

  modport slave (
    input  sysad_in, syscmd_in, pvalid_l, req_ready, wbuf_idx, rsp_valid, rsp_data, rsp_err,
    output sysad_out, syscmd_out, sysad_oe, evalid_l, eok_l, req_valid, req_write, req_block,
           req_size, req_addr, req_nwords, wbuf_data, rsp_ready, proto_err
  );

  modport master (
    output sysad_in, syscmd_in, pvalid_l, req_ready, wbuf_idx, rsp_valid, rsp_data, rsp_err,
    input  sysad_out, syscmd_out, sysad_oe, evalid_l, eok_l, req_valid, req_write, req_block,
           req_size, req_addr, req_nwords, wbuf_data, rsp_ready, proto_err
  );
endinterface

// File: rtl/rcp_sysad_slave.sv
// RCP-side SysAD slave: decodes CPU address phases, buffers write bursts, issues one internal
// request per transaction and streams read responses back to the CPU with evalid_l.
module rcp_sysad_slave #(
  parameter bit RSP_ERR_ON_RSVD = 1'b1
) (
  input logic              sysclk,
  input logic              reset_l,
  rcp_sysad_slave_if.slave bus
);
  localparam logic [4:0] CmdMore = 5'b11000;
  localparam logic [4:0] CmdLast = 5'b10000;

  typedef enum logic [2:0] {StIdle, StWdata, StWreq, StRreq, StRsp} state_e;

  state_e      st_q, st_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d, block_q, block_d, rsvd_q, rsvd_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  nwords_q, nwords_d, cnt_q, cnt_d;
  logic [31:0] wbuf_q [8];
  logic [31:0] wbuf_d [8];
  logic [31:0] sysad_out_q, sysad_out_d;
  logic [4:0]  syscmd_out_q, syscmd_out_d;
  logic        sysad_oe_q, sysad_oe_d, evalid_l_q, evalid_l_d;
  logic        eok_l_q, eok_l_d, proto_err_q, proto_err_d;
  logic        cnt_last, rsp_pend, rsp_take;

  assign cnt_last = (cnt_q + 4'd1) == nwords_q;
  assign rsp_pend = (st_q == StRsp) && (cnt_q != nwords_q);
  // Reserved-size reads synthesize their own error words instead of waiting on the target.
  assign rsp_take = rsp_pend && (rsvd_q || bus.rsp_valid);

  always_comb begin
    st_d         = st_q;
    addr_d       = addr_q;
    write_d      = write_q;
    block_d      = block_q;
    rsvd_d       = rsvd_q;
    size_d       = size_q;
    nwords_d     = nwords_q;
    cnt_d        = cnt_q;
    wbuf_d       = wbuf_q;
    sysad_out_d  = sysad_out_q;
    syscmd_out_d = syscmd_out_q;
    sysad_oe_d   = sysad_oe_q;
    evalid_l_d   = 1'b1;
    proto_err_d  = 1'b0;

    unique case (st_q)
      StIdle: begin
        if (!bus.pvalid_l) begin
          if (bus.syscmd_in[4]) begin
            proto_err_d = 1'b1;
          end else begin
            addr_d  = bus.sysad_in;
            write_d = bus.syscmd_in[3];
            block_d = bus.syscmd_in[2];
            size_d  = bus.syscmd_in[1:0];
            cnt_d   = 4'd0;
            rsvd_d  = 1'b0;
            if (!bus.syscmd_in[2]) nwords_d = 4'd1;
            else if (bus.syscmd_in[1:0] == 2'b00) nwords_d = 4'd2;
            else if (bus.syscmd_in[1:0] == 2'b01) nwords_d = 4'd4;
            else if (bus.syscmd_in[1:0] == 2'b10) nwords_d = 4'd8;
            else nwords_d = 4'd2;
            if (bus.syscmd_in[2] && (bus.syscmd_in[1:0] == 2'b11)) begin
              proto_err_d = 1'b1;
              if (!bus.syscmd_in[3] && RSP_ERR_ON_RSVD) begin
                rsvd_d = 1'b1;
                st_d   = StRsp;
              end
            end else begin
              st_d = bus.syscmd_in[3] ? StWdata : StRreq;
            end
          end
        end
      end
      StWdata: begin
        if (!bus.pvalid_l) begin
          wbuf_d[cnt_q[2:0]] = bus.sysad_in;
          cnt_d = cnt_q + 4'd1;
          if ((bus.syscmd_in == CmdLast) && cnt_last) begin
            st_d = StWreq;
          end else if (!((bus.syscmd_in == CmdMore) && !cnt_last)) begin
            proto_err_d = 1'b1;
            st_d        = StIdle;
          end
        end
      end
      StWreq: if (bus.req_ready) st_d = StIdle;
      StRreq: if (bus.req_ready) st_d = StRsp;
      StRsp: begin
        // Leave once the word flagged last has been on the bus for its cycle.
        if (!evalid_l_q && !syscmd_out_q[3]) begin
          st_d       = StIdle;
          sysad_oe_d = 1'b0;
        end
      end
      default: st_d = StIdle;
    endcase

    if (rsp_take) begin
      cnt_d        = cnt_q + 4'd1;
      evalid_l_d   = 1'b0;
      sysad_oe_d   = 1'b1;
      sysad_out_d  = rsvd_q ? 32'd0 : bus.rsp_data;
      syscmd_out_d = {1'b1, ~cnt_last, 1'b0, rsvd_q | bus.rsp_err, 1'b0};
    end

    // Registered so eok_l stays deasserted while reset is held.
    eok_l_d = !((st_d == StIdle) || (st_d == StWdata) || ((st_d == StRreq) && (st_q != StRreq)));
  end

  always_ff @(posedge sysclk or negedge reset_l) begin
    if (!reset_l) begin
      st_q         <= StIdle;
      addr_q       <= '0;
      write_q      <= 1'b0;
      block_q      <= 1'b0;
      rsvd_q       <= 1'b0;
      size_q       <= '0;
      nwords_q     <= 4'd1;
      cnt_q        <= '0;
      wbuf_q       <= '{default: '0};
      sysad_out_q  <= '0;
      syscmd_out_q <= '0;
      sysad_oe_q   <= 1'b0;
      evalid_l_q   <= 1'b1;
      eok_l_q      <= 1'b1;
      proto_err_q  <= 1'b0;
    end else begin
      st_q         <= st_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      block_q      <= block_d;
      rsvd_q       <= rsvd_d;
      size_q       <= size_d;
      nwords_q     <= nwords_d;
      cnt_q        <= cnt_d;
      wbuf_q       <= wbuf_d;
      sysad_out_q  <= sysad_out_d;
      syscmd_out_q <= syscmd_out_d;
      sysad_oe_q   <= sysad_oe_d;
      evalid_l_q   <= evalid_l_d;
      eok_l_q      <= eok_l_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign bus.sysad_out  = sysad_out_q;
  assign bus.syscmd_out = syscmd_out_q;
  assign bus.sysad_oe   = sysad_oe_q;
  assign bus.evalid_l   = evalid_l_q;
  assign bus.eok_l      = eok_l_q;
  assign bus.proto_err  = proto_err_q;
  assign bus.req_valid  = (st_q == StWreq) || (st_q == StRreq);
  assign bus.req_write  = write_q;
  assign bus.req_block  = block_q;
  assign bus.req_size   = size_q;
  assign bus.req_addr   = addr_q;
  assign bus.req_nwords = nwords_q;
  assign bus.rsp_ready  = rsp_pend && !rsvd_q;
  assign bus.wbuf_data  = wbuf_q[bus.wbuf_idx];
endmodule

// File: tb/tb_rcp_sysad_slave.sv
// Directed plus randomized bench for rcp_sysad_slave; the bench plays both CPU and target and
// predicts every output from the SysAD transaction rules.
module tb_rcp_sysad_slave;
  logic sysclk;
  logic reset_l;
  rcp_sysad_slave_if bus ();

  rcp_sysad_slave #(.RSP_ERR_ON_RSVD(1'b1)) dut (
    .sysclk (sysclk),
    .reset_l(reset_l),
    .bus    (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] wdat [8];
  logic [31:0] rdat [8];
  logic        rerr [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle_cpu();
    bus.pvalid_l  = 1'b1;
    bus.syscmd_in = 5'b00000;
    bus.sysad_in  = $urandom;
  endtask

  function automatic int nwords_of(input bit block, input logic [1:0] size);
    int tab [3] = '{2, 4, 8};
    if (!block) return 1;
    return tab[size];
  endfunction

  // bad_last >= 0 places a premature "last" on that data word.
  task automatic do_write(input bit block, input logic [1:0] size, input logic [31:0] addr,
                          input int bad_last, input int stall, input bit preset);
    int n = nwords_of(block, size);
    check("eok_before_waddr", bus.eok_l, 0);
    bus.pvalid_l  = 1'b0;
    bus.syscmd_in = {2'b01, block, size};
    bus.sysad_in  = addr;
    tick();
    for (int i = 0; i < n; i++) begin
      if (!preset) wdat[i] = $urandom;
      bus.pvalid_l  = 1'b0;
      bus.sysad_in  = wdat[i];
      bus.syscmd_in = ((i == n - 1) || (i == bad_last)) ? 5'b10000 : 5'b11000;
      check("eok_wdata", bus.eok_l, 0);
      tick();
      if (i == bad_last) break;
    end
    idle_cpu();
    if (bad_last >= 0) begin
      check("perr_pulse", bus.proto_err, 1);
      check("perr_no_req", bus.req_valid, 0);
      check("perr_eok", bus.eok_l, 0);
      tick();
      check("perr_one_cycle", bus.proto_err, 0);
      check("perr_no_req2", bus.req_valid, 0);
      return;
    end
    check("wreq_valid", bus.req_valid, 1);
    check("wreq_write", bus.req_write, 1);
    check("wreq_block", bus.req_block, block);
    check("wreq_size", bus.req_size, size);
    check("wreq_addr", bus.req_addr, addr);
    check("wreq_nwords", bus.req_nwords, n);
    check("wreq_eok", bus.eok_l, 1);
    for (int k = 0; k < stall; k++) begin
      tick();
      check("wreq_hold", bus.req_valid, 1);
    end
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    check("wdone_req", bus.req_valid, 0);
    check("wdone_eok", bus.eok_l, 0);
    for (int j = 0; j < n; j++) begin
      bus.wbuf_idx = j[2:0];
      tick();
      check("wbuf_word", bus.wbuf_data, wdat[j]);
    end
  endtask

  // reset_at >= 0 pulls reset while that response word is on the bus.
  task automatic do_read(input bit block, input logic [1:0] size, input logic [31:0] addr,
                         input bit gap, input int stall, input int reset_at, input bit preset);
    int n = nwords_of(block, size);
    if (!preset) begin
      for (int i = 0; i < n; i++) begin
        rdat[i] = $urandom;
        rerr[i] = 1'($urandom_range(0, 1));
      end
    end
    check("eok_before_raddr", bus.eok_l, 0);
    bus.pvalid_l  = 1'b0;
    bus.syscmd_in = {2'b00, block, size};
    bus.sysad_in  = addr;
    tick();
    idle_cpu();
    check("rreq_valid", bus.req_valid, 1);
    check("rreq_write", bus.req_write, 0);
    check("rreq_addr", bus.req_addr, addr);
    check("rreq_nwords", bus.req_nwords, n);
    check("rreq_turnaround", bus.sysad_oe, 0);
    check("rreq_eok_first", bus.eok_l, 0);
    for (int k = 0; k < stall; k++) begin
      tick();
      check("rreq_stall_eok", bus.eok_l, 1);
      check("rreq_stall_oe", bus.sysad_oe, 0);
      check("rreq_stall_valid", bus.req_valid, 1);
    end
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    check("rsp_req_drop", bus.req_valid, 0);
    check("rsp_eok", bus.eok_l, 1);
    for (int i = 0; i < n; i++) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = rdat[i];
      bus.rsp_err   = rerr[i];
      check("rsp_ready", bus.rsp_ready, 1);
      tick();
      bus.rsp_valid = 1'b0;
      check("rsp_evalid", bus.evalid_l, 0);
      check("rsp_data", bus.sysad_out, rdat[i]);
      check("rsp_cmd", bus.syscmd_out, {1'b1, (i != n - 1), 1'b0, rerr[i], 1'b0});
      check("rsp_oe", bus.sysad_oe, 1);
      if (i == reset_at) begin
        reset_l = 1'b0;
        #1;
        check("rst_oe", bus.sysad_oe, 0);
        check("rst_evalid", bus.evalid_l, 1);
        check("rst_eok", bus.eok_l, 1);
        @(negedge sysclk);
        reset_l = 1'b1;
        tick();
        check("rst_eok_after", bus.eok_l, 0);
        check("rst_no_req", bus.req_valid, 0);
        return;
      end
      if (gap && (i != n - 1)) begin
        tick();
        check("gap_evalid", bus.evalid_l, 1);
        check("gap_oe", bus.sysad_oe, 1);
      end
    end
    tick();
    check("rend_oe", bus.sysad_oe, 0);
    check("rend_evalid", bus.evalid_l, 1);
    check("rend_eok", bus.eok_l, 0);
  endtask

  initial begin
    idle_cpu();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    bus.wbuf_idx  = '0;
    reset_l       = 1'b0;
    tick();
    tick();
    check("rst_eok", bus.eok_l, 1);
    check("rst_evalid", bus.evalid_l, 1);
    check("rst_oe", bus.sysad_oe, 0);
    check("rst_sysad", bus.sysad_out, 0);
    check("rst_syscmd", bus.syscmd_out, 0);
    check("rst_req", bus.req_valid, 0);
    check("rst_rsp_ready", bus.rsp_ready, 0);
    check("rst_perr", bus.proto_err, 0);
    #2 reset_l = 1'b1;
    tick();
    check("eok_after_rst", bus.eok_l, 0);

    rdat[0] = 32'hdeadbeef;
    rerr[0] = 1'b0;
    do_read(1'b0, 2'b11, 32'h0400_0000, 1'b0, 0, -1, 1'b1);

    do_write(1'b1, 2'b10, 32'h0000_0100, -1, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rdat[i] = $urandom;
      rerr[i] = 1'b1;
    end
    do_read(1'b1, 2'b01, 32'h0000_2000, 1'b1, 0, -1, 1'b1);

    do_write(1'b1, 2'b01, 32'h0000_0040, 2, 0, 1'b0);

    // Reserved block size on a read: two synthesized error words.
    bus.pvalid_l  = 1'b0;
    bus.syscmd_in = 5'b00111;
    bus.sysad_in  = 32'h0000_3000;
    tick();
    idle_cpu();
    check("rsvd_perr", bus.proto_err, 1);
    check("rsvd_no_req", bus.req_valid, 0);
    check("rsvd_turnaround", bus.sysad_oe, 0);
    tick();
    check("rsvd_w0_evalid", bus.evalid_l, 0);
    check("rsvd_w0_data", bus.sysad_out, 0);
    check("rsvd_w0_cmd", bus.syscmd_out, 5'b11010);
    check("rsvd_perr_off", bus.proto_err, 0);
    tick();
    check("rsvd_w1_cmd", bus.syscmd_out, 5'b10010);
    check("rsvd_w1_evalid", bus.evalid_l, 0);
    tick();
    check("rsvd_end_oe", bus.sysad_oe, 0);
    check("rsvd_end_eok", bus.eok_l, 0);

    // Data-style command seen in IDLE.
    bus.pvalid_l  = 1'b0;
    bus.syscmd_in = 5'b11000;
    tick();
    idle_cpu();
    check("stray_perr", bus.proto_err, 1);
    check("stray_no_req", bus.req_valid, 0);
    tick();
    check("stray_perr_off", bus.proto_err, 0);

    do_read(1'b1, 2'b10, 32'h0000_4000, 1'b0, 0, 2, 1'b0);
    wdat[0] = 32'h1234_5678;
    do_write(1'b0, 2'b00, 32'h0000_0000, -1, 0, 1'b1);

    do_read(1'b0, 2'b00, 32'h0000_5000, 1'b0, 50, -1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      logic [1:0]  kind;
      logic [1:0]  size;
      logic [31:0] addr;
      kind = 2'($urandom_range(0, 3));
      size = 2'($urandom_range(0, 2));
      addr = $urandom & 32'hffff_fffc;
      if (kind[1]) do_write(kind[0], size, addr, -1, $urandom_range(0, 3), 1'b0);
      else do_read(kind[0], size, addr, 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
